// File: rtl/ether_fcs_tx_if.sv
// ether_fcs_tx_if: frame-stream bus into and out of the FCS inserter (beat width N).
interface ether_fcs_tx_if #(
   parameter int unsigned N = 2
);
   logic [N-1:0] axiid;
   logic         axiiv;
   logic         axii_cksum;
   logic [N-1:0] axiod;
   logic         axiov;
   logic         busy;
   logic         err;

   modport master (
      output axiid, axiiv, axii_cksum,
      input  axiod, axiov, busy, err
   );

   modport slave (
      input  axiid, axiiv, axii_cksum,
      output axiod, axiov, busy, err
   );
endinterface

// File: rtl/ether_fcs_tx.sv
// ether_fcs_tx: forwards a dibit/nibble frame with one cycle of latency, appends the Ethernet FCS
// and enforces the IPG. Define ETHER_FCS_PAD_EN to zero-pad short frames up to MIN_BYTES.
module ether_fcs_tx #(
   parameter int unsigned N         = 2,
   parameter int unsigned IPG_BITS  = 96,
   parameter int unsigned MIN_BYTES = 60
) (
   input logic           clk,
   input logic           rst,
   ether_fcs_tx_if.slave bus_io
);
   localparam int unsigned Bpb      = 8 / N;
   localparam int unsigned FcsBeats = 32 / N;
   localparam int unsigned IpgCyc   = IPG_BITS / N;
   localparam logic [31:0] CrcInit  = 32'hFFFF_FFFF;
   localparam logic [31:0] CrcPoly  = 32'hEDB8_8320;

   if (!((N == 2) || (N == 4)) || (MIN_BYTES > 65535)) begin : g_bad_param
      $error("ether_fcs_tx: N must be 2 or 4 and MIN_BYTES must fit in 16 bits");
   end

   typedef enum logic [2:0] {
      StIdle,
      StPass,
`ifdef ETHER_FCS_PAD_EN
      StPad,
`endif
      StFcs,
      StIpg
   } state_e;

   state_e       state_q, state_d;
   logic [31:0]  crc_q, crc_d;
   logic [7:0]   acc_q, acc_d;
   logic [1:0]   beat_q, beat_d;
   logic [15:0]  cnt_q, cnt_d;
   logic         wait_low_q, wait_low_d;
   logic [N-1:0] axiod_q, axiod_d;
   logic         axiov_q, axiov_d;
   logic         err_q, err_d;
`ifdef ETHER_FCS_PAD_EN
   logic [15:0]  bcnt_q, bcnt_d;
`endif

   logic         feed;
   logic [N-1:0] feed_bits;
   logic [31:0]  fcs_word;
   logic [N-1:0] fcs_beat;
   logic         busy;

   // Reflected CRC-32 over one byte, bit 0 first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ CrcPoly) : (r >> 1);
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         crc_q      <= CrcInit;
         acc_q      <= '0;
         beat_q     <= '0;
         cnt_q      <= '0;
         wait_low_q <= 1'b1;
         axiod_q    <= '0;
         axiov_q    <= 1'b0;
         err_q      <= 1'b0;
`ifdef ETHER_FCS_PAD_EN
         bcnt_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         crc_q      <= crc_d;
         acc_q      <= acc_d;
         beat_q     <= beat_d;
         cnt_q      <= cnt_d;
         wait_low_q <= wait_low_d;
         axiod_q    <= axiod_d;
         axiov_q    <= axiov_d;
         err_q      <= err_d;
`ifdef ETHER_FCS_PAD_EN
         bcnt_q     <= bcnt_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      crc_d      = crc_q;
      acc_d      = acc_q;
      beat_d     = beat_q;
      cnt_d      = cnt_q;
      wait_low_d = wait_low_q;
      axiod_d    = '0;
      axiov_d    = 1'b0;
      err_d      = 1'b0;
      feed       = 1'b0;
      feed_bits  = bus_io.axiid;
`ifdef ETHER_FCS_PAD_EN
      bcnt_d     = bcnt_q;
`endif
      if (!bus_io.axiiv) wait_low_d = 1'b0;
      // Overrun: flag the run once and keep its tail from starting a frame.
      if (busy && bus_io.axiiv) begin
         wait_low_d = 1'b1;
         err_d      = !wait_low_q;
      end

      unique case (state_q)
         StIdle: begin
            crc_d  = CrcInit;
            acc_d  = '0;
            beat_d = '0;
            cnt_d  = '0;
`ifdef ETHER_FCS_PAD_EN
            bcnt_d = '0;
`endif
            if (bus_io.axiiv && !wait_low_q) begin
               state_d = StPass;
               axiod_d = bus_io.axiid;
               axiov_d = 1'b1;
               feed    = bus_io.axii_cksum;
            end
         end
         StPass: begin
            if (bus_io.axiiv) begin
               axiod_d = bus_io.axiid;
               axiov_d = 1'b1;
               feed    = bus_io.axii_cksum;
            end else begin
               err_d   = (beat_q != 2'd0);
               acc_d   = '0;
               beat_d  = '0;
               axiov_d = 1'b1;
`ifdef ETHER_FCS_PAD_EN
               if (bcnt_q < 16'(MIN_BYTES)) begin
                  state_d   = StPad;
                  feed      = 1'b1;
                  feed_bits = '0;
               end else
`endif
               begin
                  state_d = StFcs;
                  axiod_d = fcs_beat;
                  cnt_d   = 16'd1;
               end
            end
         end
`ifdef ETHER_FCS_PAD_EN
         StPad: begin
            axiov_d   = 1'b1;
            feed      = 1'b1;
            feed_bits = '0;
         end
`endif
         StFcs: begin
            axiov_d = 1'b1;
            axiod_d = fcs_beat;
            cnt_d   = cnt_q + 16'd1;
            if (cnt_q == 16'(FcsBeats - 1)) begin
               state_d = StIpg;
               cnt_d   = '0;
            end
         end
         StIpg: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == 16'(IpgCyc - 1)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
         default: state_d = StIdle;
      endcase

      // Beats fill the byte MSB-first; the CRC advances once per completed byte.
      if (feed) begin
         acc_d[7 - N * beat_d -: N] = feed_bits;
         if (beat_d == 2'(Bpb - 1)) begin
            crc_d  = crc_byte(crc_d, acc_d);
            beat_d = '0;
`ifdef ETHER_FCS_PAD_EN
            bcnt_d = bcnt_d + 16'd1;
`endif
         end else begin
            beat_d = beat_d + 2'd1;
         end
      end
`ifdef ETHER_FCS_PAD_EN
      if ((state_q == StPad) && (bcnt_d == 16'(MIN_BYTES))) state_d = StFcs;
`endif
   end

   always_comb begin
      // FCS bytes low byte first, each MSB-first, flattened into one left-to-right word.
      fcs_word = {~crc_q[7:0], ~crc_q[15:8], ~crc_q[23:16], ~crc_q[31:24]} << (N * cnt_q);
      fcs_beat = fcs_word[31 -: N];
      busy     = (state_q != StIdle) && (state_q != StPass);
   end

   assign bus_io.axiod = axiod_q;
   assign bus_io.axiov = axiov_q;
   assign bus_io.err   = err_q;
   assign bus_io.busy  = busy;
endmodule

// File: tb/tb_ether_fcs_tx.sv
// tb_ether_fcs_tx: directed and randomized frames on N=2 and N=4 instances, checked against a
// byte-level model of the forwarded stream, padding, FCS, error pulses and IPG length.
module tb_ether_fcs_tx;
   typedef logic [7:0] bytes_t [$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int unsigned d0 [$];
   int          c0 [$];
   int unsigned d1 [$];
   int          c1 [$];
   int errs [2]      = '{0, 0};
   int fall_c [2]    = '{0, 0};
   bit busy_prev [2] = '{1'b0, 1'b0};

   ether_fcs_tx_if #(.N(2)) b2 ();
   ether_fcs_tx_if #(.N(4)) b4 ();

   ether_fcs_tx #(.N(2)) u_dut2 (.clk(clk), .rst(rst), .bus_io(b2.slave));
   ether_fcs_tx #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .bus_io(b4.slave));

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (b2.axiov) begin d0.push_back(32'(b2.axiod)); c0.push_back(cyc); end
      if (b4.axiov) begin d1.push_back(32'(b4.axiod)); c1.push_back(cyc); end
      if (b2.err) errs[0] <= errs[0] + 1;
      if (b4.err) errs[1] <= errs[1] + 1;
      if (busy_prev[0] && !b2.busy) fall_c[0] <= cyc;
      if (busy_prev[1] && !b4.busy) fall_c[1] <= cyc;
      busy_prev[0] <= b2.busy;
      busy_prev[1] <= b4.busy;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Bit-serial reference: message bits LSB-first into the reflected register.
   function automatic logic [31:0] ref_fcs(input bytes_t m);
      logic [31:0] r;
      bit fb;
      r = 32'hFFFF_FFFF;
      foreach (m[i]) begin
         for (int b = 0; b < 8; b++) begin
            fb = r[0] ^ m[i][b];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB8_8320;
         end
      end
      return ~r;
   endfunction

   function automatic bytes_t rand_bytes(input int n);
      bytes_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic drive(input int w, input int unsigned d, input bit v, input bit c);
      @(negedge clk);
      if (w == 0) begin
         b2.axiid = d[1:0]; b2.axiiv = v; b2.axii_cksum = c;
      end else begin
         b4.axiid = d[3:0]; b4.axiiv = v; b4.axii_cksum = c;
      end
   endtask

   task automatic run_frame(input int w, input string tag, input int npre, input bytes_t data,
                            input int npart, input int ovr_at, input int ovr_len);
      int n, bpb, st_idx, st_err, st_cyc, t, bad, sz;
      int unsigned mask;
      int unsigned beats [$];
      bit          cks [$];
      int unsigned expd [$];
      int unsigned gd [$];
      int          gc [$];
      bytes_t      crcb;
      logic [31:0] f;
      n = (w == 0) ? 2 : 4;
      bpb = 8 / n;
      mask = (32'd1 << n) - 1;
      for (int i = 0; i < npre; i++) begin beats.push_back($urandom & mask); cks.push_back(1'b0); end
      foreach (data[i]) begin
         for (int j = 0; j < bpb; j++) begin
            beats.push_back((32'(data[i]) >> (8 - n * (j + 1))) & mask);
            cks.push_back(1'b1);
         end
      end
      for (int i = 0; i < npart; i++) begin beats.push_back($urandom & mask); cks.push_back(1'b1); end
      expd = beats;
      crcb = data;
`ifdef ETHER_FCS_PAD_EN
      while (crcb.size() < 60) begin
         crcb.push_back(8'h00);
         for (int j = 0; j < bpb; j++) expd.push_back(0);
      end
`endif
      f = ref_fcs(crcb);
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < bpb; j++)
            expd.push_back((32'(f[8*k +: 8]) >> (8 - n * (j + 1))) & mask);

      st_idx = (w == 0) ? d0.size() : d1.size();
      st_err = errs[w];
      st_cyc = cyc;
      foreach (beats[i]) drive(w, beats[i], 1'b1, cks[i]);
      drive(w, 0, 1'b0, 1'b0);
      if (ovr_at >= 0) begin
         repeat (ovr_at) @(negedge clk);
         for (int i = 0; i < ovr_len; i++) drive(w, $urandom & mask, 1'b1, 1'b1);
         drive(w, 0, 1'b0, 1'b0);
      end
      t = 0;
      while (fall_c[w] <= st_cyc && t < 4000) begin @(negedge clk); t++; end
      chk({tag, "_busy_fall"}, 64'(t < 4000), 1);
      repeat (2) @(negedge clk);

      sz = (w == 0) ? d0.size() : d1.size();
      for (int i = st_idx; i < sz; i++) begin
         gd.push_back((w == 0) ? d0[i] : d1[i]);
         gc.push_back((w == 0) ? c0[i] : c1[i]);
      end
      chk({tag, "_len"}, gd.size(), expd.size());
      bad = 0;
      foreach (expd[i]) if (i >= gd.size() || gd[i] != expd[i]) bad++;
      chk({tag, "_beats_bad"}, bad, 0);
      if (gd.size() > 0) begin
         chk({tag, "_contig"}, gc[gc.size()-1] - gc[0] + 1, gd.size());
         chk({tag, "_ipg"}, fall_c[w] - gc[gc.size()-1], 96 / n);
      end
      chk({tag, "_err"}, errs[w] - st_err, int'(npart != 0) + int'(ovr_at >= 0));
   endtask

   // Rebuild the last four output bytes from the stream tail and compare with fixed values.
   task automatic check_tail(input int w, input string tag);
      logic [7:0] kv [4] = '{8'h26, 8'h39, 8'hF4, 8'hCB};
      int n, bpb, sz, idx;
      logic [7:0] b;
      n = (w == 0) ? 2 : 4;
      bpb = 8 / n;
      sz = (w == 0) ? d0.size() : d1.size();
      for (int k = 0; k < 4; k++) begin
         b = '0;
         for (int j = 0; j < bpb; j++) begin
            idx = sz - 4 * bpb + k * bpb + j;
            b = (b << n) | 8'((w == 0) ? d0[idx] : d1[idx]);
         end
         chk($sformatf("%s_fcs%0d", tag, k), b, kv[k]);
      end
   endtask

   initial begin
      bytes_t vec;
      string  s;
      int     idx;
      s = "123456789";
      for (int i = 0; i < s.len(); i++) vec.push_back(s[i]);
      b2.axiid = '0; b2.axiiv = 1'b1; b2.axii_cksum = 1'b1;
      b4.axiid = '0; b4.axiiv = 1'b0; b4.axii_cksum = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_axiov2", b2.axiov, 0);
      chk("rst_axiod2", b2.axiod, 0);
      chk("rst_busy2", b2.busy, 0);
      chk("rst_err2", b2.err, 0);
      chk("rst_axiov4", b4.axiov, 0);
      rst = 1'b0;
      // axiiv held high through reset release must not start a frame
      repeat (6) @(negedge clk);
      chk("wait_low_after_rst", d0.size(), 0);
      drive(0, 0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      run_frame(0, "vec2", 32, vec, 0, -1, 0);
`ifndef ETHER_FCS_PAD_EN
      check_tail(0, "vec2");
`endif
      run_frame(1, "vec4", 16, vec, 0, -1, 0);
`ifndef ETHER_FCS_PAD_EN
      check_tail(1, "vec4");
`endif
      run_frame(0, "hdr14", 32, rand_bytes(14), 0, -1, 0);
      for (int i = 0; i < 3; i++)
         run_frame(0, $sformatf("rnd2_%0d", i), $urandom_range(0, 32),
                   rand_bytes($urandom_range(1, 70)), 0, -1, 0);
      for (int i = 0; i < 2; i++)
         run_frame(1, $sformatf("rnd4_%0d", i), $urandom_range(0, 16),
                   rand_bytes($urandom_range(1, 70)), 0, -1, 0);
      run_frame(0, "part2", 8, rand_bytes($urandom_range(1, 20)), $urandom_range(1, 3), -1, 0);
      run_frame(1, "part4", 8, rand_bytes($urandom_range(1, 20)), 1, -1, 0);
      run_frame(0, "ovr_ipg5", 8, rand_bytes(10), 0, 16 + 5, 10);
      run_frame(0, "ovr_cross", 8, rand_bytes(10), 0, 16 + 40, 20);
      run_frame(0, "after_ovr", 8, rand_bytes(12), 0, -1, 0);

      for (int i = 0; i < 30; i++) drive(0, $urandom & 3, 1'b1, 1'b1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("midrst_axiov", b2.axiov, 0);
      chk("midrst_busy", b2.busy, 0);
      idx = d0.size();
      for (int i = 0; i < 12; i++) drive(0, $urandom & 3, 1'b1, 1'b1);
      drive(0, 0, 1'b0, 1'b0);
      repeat (80) @(negedge clk);
      chk("midrst_no_out", d0.size() - idx, 0);
      run_frame(0, "after_rst", 16, rand_bytes(20), 0, -1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
